// File: rtl/marquee_pkg.sv
// Shared types for the marquee control stage: FSM states and scroll direction encoding.
// No logic here; no latency or backpressure.
package marquee_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge press pulse.
// Press appears 2 + DEB_CYCLES + 1 cycles after a clean rise; no backpressure (free-running).
module btn_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          lvl_prev;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            lvl_prev <= 1'b0;
            press    <= 1'b0;
            level    <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            lvl_prev <= level;
            press    <= level & ~lvl_prev;
            // Any cycle where the input agrees with the accepted level restarts the count.
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                level   <= ~level;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/marquee_ctrl.sv
// Scanner refresh strobe plus ping-pong scroll offset, started/paused/resumed by one button.
// Registered outputs, one-cycle latency from internal events; no backpressure (scanner always accepts).
module marquee_ctrl
    import marquee_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int STEP_TICKS = 250,
    parameter int DEB_CYCLES = 100000,
    parameter int SHIFT_MAX  = 3,
    parameter int SHIFT_W    = 3
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               btn_raw,
    output logic               scan_tick,
    output logic [SHIFT_W-1:0] shift,
    output logic               dir,
    output logic               running
);

    localparam int                 SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam int                 STEP_W    = $clog2(STEP_TICKS + 1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [SHIFT_W-1:0] SMAX      = SHIFT_W'(SHIFT_MAX);

    logic              btn_level_unused;
    logic              press;
    logic [SCAN_W-1:0] scan_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic              step;
    state_t            state_q;
    state_t            state_d;
    logic              running_d;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk    (clk),
        .nrst   (nrst),
        .btn_raw(btn_raw),
        .level  (btn_level_unused),
        .press  (press)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= (scan_cnt == SCAN_LAST);
            scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
        end
    end

    assign step = (state_q == RUN) && scan_tick && (step_cnt == STEP_LAST);

    // Step phase survives a pause so resuming does not restart the step interval.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            step_cnt <= '0;
        end else if (state_q == IDLE) begin
            step_cnt <= '0;
        end else if (state_q == RUN && scan_tick) begin
            step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = RUN;
            RUN:     if (press) state_d = HOLD;
            HOLD:    if (press) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running_d = (state_d == RUN);
    end

    // A press coinciding with a step pauses without moving the offset.
    always_ff @(posedge clk) begin
        if (!nrst || state_q == IDLE) begin
            shift <= '0;
            dir   <= DIR_UP;
        end else if (step && !press) begin
            if (dir == DIR_UP) begin
                if (shift < SMAX) begin
                    shift <= shift + 1'b1;
                end else begin
                    dir   <= DIR_DOWN;
                    shift <= (shift != '0) ? shift - 1'b1 : shift;
                end
            end else begin
                if (shift != '0) begin
                    shift <= shift - 1'b1;
                end else begin
                    dir   <= DIR_UP;
                    shift <= (shift < SMAX) ? shift + 1'b1 : shift;
                end
            end
        end
    end

endmodule
